val_seq_monitor: RTL and testbench
==================================

// Module: val_seq_monitor
// PURPOSE
//   Receiving end of the free-running value stream driven by our VPI test tops:
//   samples a WIDTH-bit incrementing value, checks it advances by exactly +1
//   modulo 2^WIDTH, and keeps good/error/wrap statistics.
//   A VPI task or host model reads the statistics through a req/ack snapshot
//   handshake. It sits beside the stimulus counter in test tops as its checker.
// PARAMETERS
//   WIDTH   12  width of monitored value
//   CNT_W   16  width of each statistics counter (saturating)
//   LOCK_N  2   consecutive +1 steps required to enter LOCKED (>=1)
//   LOSS_N  3   consecutive mismatches in LOCKED that drop back to SEARCH (>=1)
// PORTS
//   clk            in   1      single clock, all logic on posedge
//   rst            in   1      synchronous, active-high reset
//   in_valid       in   1      in_val is a sample this cycle
//   in_val         in   WIDTH  sampled value
//   snap_req       in   1      level request; rising edge triggers snapshot
//   snap_ack       out  1      one-cycle pulse: snapshot outputs are valid
//   locked         out  1      state == LOCKED
//   err_pulse      out  1      one-cycle pulse, cycle after a counted mismatch
//   snap_good      out  CNT_W  snapshot: matched samples while LOCKED
//   snap_err       out  CNT_W  snapshot: mismatched samples while LOCKED
//   snap_wrap      out  CNT_W  snapshot: matched all-ones -> 0 transitions
//   snap_first_exp out  WIDTH  snapshot: expected value at first error
//   snap_first_got out  WIDTH  snapshot: received value at first error
// BEHAVIOUR
//   Reset: every output, live counter, snapshot register and expected value = 0;
//     state = SEARCH; first-error flag cleared; snap_req edge detector = 0.
//   Match: in_valid && in_val == expected. Expected <= in_val + 1, mod 2^WIDTH,
//     on every valid sample in both states (immediate resync).
//   SEARCH: run counter counts matches. A mismatch (or the first sample after
//     reset) sets run = 0 and counts nothing. run reaching LOCK_N -> LOCKED,
//     run cleared. SEARCH samples never touch the statistics.
//   LOCKED:
//     - match: good++; also wrap++ if in_val == 0; miss run = 0.
//     - mismatch: err++; err_pulse = 1 next cycle. First error since
//       reset/snapshot latches {expected, in_val}. miss run++.
//     - miss run reaching LOSS_N -> SEARCH, run counters cleared.
//   Idle cycles (in_valid = 0) change nothing; runs are not broken.
//   Counters saturate at all-ones and never wrap.
//   Snapshot: snap_req 0->1 seen on cycle T. Snapshot registers load the live
//     values including the update from any sample accepted on cycle T. snap_ack
//     = 1 on T+1 only. Live counters and first-error flag clear on T; a sample
//     on T is counted in the snapshot, not in the new live values. Holding
//     snap_req high does not retrigger. Snapshot outputs hold until the next
//     snapshot or reset. State and expected value are not affected.
//   Reset mid-operation: takes priority over samples and snapshot requests;
//     a pending ack is dropped.
//   Latency: locked updates the cycle after the deciding sample; err_pulse and
//     snap_ack are registered one-cycle pulses.
// STRUCTURE
//   Package val_mon_pkg: state_t enum {SEARCH, LOCKED}; default WIDTH/CNT_W
//     constants.
//   Sub-module sat_counter #(W): clear/inc, saturating. Instantiated for good,
//     err and wrap counters.
//   Top holds the FSM, expected register, run counters, edge detect and
//     snapshot registers.
// TESTING
//   1. Reset, then 0,1,2..9 on consecutive cycles, then snapshot ->
//      locked on the cycle after sample 2. snap_good = 7, err = 0, wrap = 0.
//   2. Locked stream 4094,4095,0,1, then snapshot -> snap_wrap = 1,
//      snap_good = 4, err = 0.
//   3. Locked at 10,11, then 20,21 -> err = 1, err_pulse one cycle after
//      sample 20, first_exp = 12, first_got = 20. Still locked; 21 counted good.
//   4. Locked, then 3 random mismatching samples -> locked falls after the 3rd.
//      Then 0,1,2 -> re-lock. Errors counted = 3.
//   5. snap_req rises on the same cycle as a matching sample -> that sample is in
//      snap_good, live good = 0 afterwards. snap_req held 5 cycles -> exactly
//      one snap_ack.
//   6. CNT_W = 4, 20 locked matches -> snap_good = 15 (saturated). Assert rst
//      mid-stream -> all outputs 0 next cycle, locked = 0.

Source files
------------

// File: rtl/val_mon_pkg.sv
// val_mon_pkg
//   Shared types and default sizes for the value-sequence monitor.
//   state_t    : lock FSM state (SEARCH / LOCKED)
//   DEF_*      : default parameter values for val_seq_monitor
package val_mon_pkg;

    typedef enum logic {
        SEARCH = 1'b0,
        LOCKED = 1'b1
    } state_t;

    localparam int DEF_WIDTH  = 12;
    localparam int DEF_CNT_W  = 16;
    localparam int DEF_LOCK_N = 2;
    localparam int DEF_LOSS_N = 3;

endpackage

// File: rtl/val_seq_monitor_sat_counter.sv
// sat_counter
//   Saturating up-counter with synchronous clear.
//   clk  in   clock (posedge)
//   rst  in   synchronous active-high reset
//   clr  in   clear to zero (wins over inc)
//   inc  in   increment request
//   q    out  current count
//   nxt  out  count after this cycle's increment, before any clear; lets the
//             parent snapshot a value that includes the increment it is
//             clearing away
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] q,
    output logic [W-1:0] nxt
);

    // Holds at all-ones instead of wrapping.
    always_comb begin
        nxt = q;
        if (inc && (q != '1)) begin
            nxt = q + W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            q <= '0;
        end else begin
            q <= nxt;
        end
    end

endmodule

// File: rtl/val_seq_monitor.sv
// val_seq_monitor
//   Checks that a sampled WIDTH-bit value advances by exactly +1 (mod 2^WIDTH)
//   and keeps good / error / wrap statistics, read out through a snapshot
//   handshake.
//   clk, rst        clock and synchronous active-high reset
//   in_valid/in_val sample strobe and value
//   snap_req        level request; a rising edge takes a snapshot
//   snap_ack        one-cycle pulse, snapshot outputs valid
//   locked          FSM is in LOCKED (also serves as the FSM state view)
//   err_pulse       one-cycle pulse the cycle after a counted mismatch
//   snap_good/err/wrap          snapshot statistics
//   snap_first_exp/first_got    snapshot of the first error since last clear
//
// Handshake: snap_req is a level; only its 0->1 transition (seen on cycle T)
// triggers. On T the live statistics (including any sample on T) are copied
// into the snapshot registers and the live ones are cleared; snap_ack is high
// for exactly cycle T+1. Holding snap_req high does not retrigger.
module val_seq_monitor
    import val_mon_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int CNT_W  = DEF_CNT_W,
    parameter int LOCK_N = DEF_LOCK_N,
    parameter int LOSS_N = DEF_LOSS_N
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_val,
    input  logic             snap_req,
    output logic             snap_ack,
    output logic             locked,
    output logic             err_pulse,
    output logic [CNT_W-1:0] snap_good,
    output logic [CNT_W-1:0] snap_err,
    output logic [CNT_W-1:0] snap_wrap,
    output logic [WIDTH-1:0] snap_first_exp,
    output logic [WIDTH-1:0] snap_first_got
);

    localparam int RUN_MAX = (LOCK_N > LOSS_N) ? LOCK_N : LOSS_N;
    localparam int RUN_W   = $clog2(RUN_MAX + 1);

    state_t           state, state_n;
    logic [WIDTH-1:0] exp_q;
    logic             have_exp;     // expected value is meaningful (not first sample)
    logic [RUN_W-1:0] run_q, run_n;   // consecutive matches while SEARCH
    logic [RUN_W-1:0] miss_q, miss_n; // consecutive mismatches while LOCKED
    logic             match;
    logic             good_inc, err_inc, wrap_inc, first_load;
    logic             snap_req_q, snap_trig;
    logic             first_seen_q;
    logic [WIDTH-1:0] first_exp_q, first_got_q, first_exp_n, first_got_n;
    logic [CNT_W-1:0] good_q, good_n, err_q, err_n, wrap_q, wrap_n;

    assign snap_trig = snap_req && !snap_req_q;
    assign match     = in_valid && have_exp && (in_val == exp_q);
    assign locked    = (state == LOCKED);

    // Next-state and statistic strobes; idle cycles leave everything as is.
    always_comb begin
        state_n    = state;
        run_n      = run_q;
        miss_n     = miss_q;
        good_inc   = 1'b0;
        err_inc    = 1'b0;
        wrap_inc   = 1'b0;
        first_load = 1'b0;
        if (in_valid) begin
            case (state)
                SEARCH: begin
                    if (match) begin
                        if (run_q == RUN_W'(LOCK_N - 1)) begin
                            state_n = LOCKED;
                            run_n   = '0;
                            miss_n  = '0;
                        end else begin
                            run_n = run_q + RUN_W'(1);
                        end
                    end else begin
                        run_n = '0;
                    end
                end
                LOCKED: begin
                    if (match) begin
                        good_inc = 1'b1;
                        wrap_inc = (in_val == '0);
                        miss_n   = '0;
                    end else begin
                        err_inc    = 1'b1;
                        first_load = !first_seen_q;
                        if (miss_q == RUN_W'(LOSS_N - 1)) begin
                            state_n = SEARCH;
                            miss_n  = '0;
                            run_n   = '0;
                        end else begin
                            miss_n = miss_q + RUN_W'(1);
                        end
                    end
                end
                default: state_n = SEARCH;
            endcase
        end
    end

    assign first_exp_n = first_load ? exp_q  : first_exp_q;
    assign first_got_n = first_load ? in_val : first_got_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= SEARCH;
            run_q          <= '0;
            miss_q         <= '0;
            exp_q          <= '0;
            have_exp       <= 1'b0;
            snap_req_q     <= 1'b0;
            snap_ack       <= 1'b0;
            err_pulse      <= 1'b0;
            first_seen_q   <= 1'b0;
            first_exp_q    <= '0;
            first_got_q    <= '0;
            snap_good      <= '0;
            snap_err       <= '0;
            snap_wrap      <= '0;
            snap_first_exp <= '0;
            snap_first_got <= '0;
        end else begin
            state      <= state_n;
            run_q      <= run_n;
            miss_q     <= miss_n;
            snap_req_q <= snap_req;
            snap_ack   <= snap_trig;
            err_pulse  <= err_inc;
            // Resync on every sample so one glitch costs one error, not a stream.
            if (in_valid) begin
                exp_q    <= in_val + WIDTH'(1);
                have_exp <= 1'b1;
            end
            if (snap_trig) begin
                snap_good      <= good_n;
                snap_err       <= err_n;
                snap_wrap      <= wrap_n;
                snap_first_exp <= first_exp_n;
                snap_first_got <= first_got_n;
                first_seen_q   <= 1'b0;
                first_exp_q    <= '0;
                first_got_q    <= '0;
            end else begin
                first_seen_q <= first_seen_q || first_load;
                first_exp_q  <= first_exp_n;
                first_got_q  <= first_got_n;
            end
        end
    end

    sat_counter #(.W(CNT_W)) u_good (
        .clk (clk), .rst (rst), .clr (snap_trig), .inc (good_inc),
        .q   (good_q), .nxt (good_n)
    );

    sat_counter #(.W(CNT_W)) u_err (
        .clk (clk), .rst (rst), .clr (snap_trig), .inc (err_inc),
        .q   (err_q), .nxt (err_n)
    );

    sat_counter #(.W(CNT_W)) u_wrap (
        .clk (clk), .rst (rst), .clr (snap_trig), .inc (wrap_inc),
        .q   (wrap_q), .nxt (wrap_n)
    );

endmodule

// File: tb/tb_val_seq_monitor.sv
// Directed bench for val_seq_monitor. A second instance with 4-bit counters
// sees the same stream to exercise saturation.
module tb_val_seq_monitor;

    localparam int WIDTH = 12;
    localparam int CNT_W = 16;
    localparam int SW    = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic [WIDTH-1:0] in_val;
    logic             snap_req;

    logic             snap_ack, locked, err_pulse;
    logic [CNT_W-1:0] snap_good, snap_err, snap_wrap;
    logic [WIDTH-1:0] snap_first_exp, snap_first_got;

    logic             s_snap_ack, s_locked, s_err_pulse;
    logic [SW-1:0]    s_snap_good, s_snap_err, s_snap_wrap;
    logic [WIDTH-1:0] s_snap_first_exp, s_snap_first_got;

    int vectors     = 0;
    int miscompares = 0;
    int acks;

    // clock
    always #5 clk = ~clk;

    val_seq_monitor #(.WIDTH(WIDTH), .CNT_W(CNT_W), .LOCK_N(2), .LOSS_N(3)) dut (
        .clk            (clk),
        .rst            (rst),
        .in_valid       (in_valid),
        .in_val         (in_val),
        .snap_req       (snap_req),
        .snap_ack       (snap_ack),
        .locked         (locked),
        .err_pulse      (err_pulse),
        .snap_good      (snap_good),
        .snap_err       (snap_err),
        .snap_wrap      (snap_wrap),
        .snap_first_exp (snap_first_exp),
        .snap_first_got (snap_first_got)
    );

    val_seq_monitor #(.WIDTH(WIDTH), .CNT_W(SW), .LOCK_N(2), .LOSS_N(3)) dut_sat (
        .clk            (clk),
        .rst            (rst),
        .in_valid       (in_valid),
        .in_val         (in_val),
        .snap_req       (snap_req),
        .snap_ack       (s_snap_ack),
        .locked         (s_locked),
        .err_pulse      (s_err_pulse),
        .snap_good      (s_snap_good),
        .snap_err       (s_snap_err),
        .snap_wrap      (s_snap_wrap),
        .snap_first_exp (s_snap_first_exp),
        .snap_first_got (s_snap_first_got)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Apply one cycle of inputs; returns #1 after the edge that sampled them.
    task automatic cyc(input logic v, input int val, input logic req);
        in_valid = v;
        in_val   = WIDTH'(val);
        snap_req = req;
        @(posedge clk);
        #1;
    endtask

    initial begin
        // reset
        rst = 1'b1;
        for (int i = 0; i < 3; i++) cyc(1'b0, 0, 1'b0);
        check("rst_locked", 32'(locked), 0);
        check("rst_ack", 32'(snap_ack), 0);
        check("rst_err_pulse", 32'(err_pulse), 0);
        check("rst_good", 32'(snap_good), 0);
        check("rst_first_exp", 32'(snap_first_exp), 0);
        rst = 1'b0;

        // 1: 0..9 from reset, lock after sample 2
        cyc(1'b1, 0, 1'b0);
        check("t1_lock_s0", 32'(locked), 0);
        cyc(1'b1, 1, 1'b0);
        check("t1_lock_s1", 32'(locked), 0);
        cyc(1'b1, 2, 1'b0);
        check("t1_lock_s2", 32'(locked), 1);
        for (int i = 3; i < 10; i++) cyc(1'b1, i, 1'b0);
        cyc(1'b0, 0, 1'b1);
        check("t1_ack", 32'(snap_ack), 1);
        check("t1_good", 32'(snap_good), 7);
        check("t1_err", 32'(snap_err), 0);
        check("t1_wrap", 32'(snap_wrap), 0);
        check("t1_sat_good", 32'(s_snap_good), 7);
        cyc(1'b0, 0, 1'b0);
        check("t1_ack_low", 32'(snap_ack), 0);

        // 2: one glitch, clear it, then a wrap
        cyc(1'b1, 4092, 1'b0);
        check("t2_err_pulse", 32'(err_pulse), 1);
        cyc(1'b1, 4093, 1'b0);
        check("t2_err_pulse_low", 32'(err_pulse), 0);
        cyc(1'b0, 0, 1'b1);
        check("t2a_err", 32'(snap_err), 1);
        check("t2a_good", 32'(snap_good), 1);
        check("t2a_first_exp", 32'(snap_first_exp), 10);
        check("t2a_first_got", 32'(snap_first_got), 4092);
        cyc(1'b0, 0, 1'b0);
        cyc(1'b1, 4094, 1'b0);
        cyc(1'b1, 4095, 1'b0);
        cyc(1'b1, 0, 1'b0);
        cyc(1'b1, 1, 1'b0);
        check("t2_locked", 32'(locked), 1);
        cyc(1'b0, 0, 1'b1);
        check("t2_wrap", 32'(snap_wrap), 1);
        check("t2_good", 32'(snap_good), 4);
        check("t2_err", 32'(snap_err), 0);
        cyc(1'b0, 0, 1'b0);

        // 3: 10,11 then 20,21
        cyc(1'b1, 9, 1'b0);
        cyc(1'b1, 10, 1'b0);
        cyc(1'b1, 11, 1'b0);
        cyc(1'b0, 0, 1'b1);
        check("t3a_err", 32'(snap_err), 1);
        check("t3a_good", 32'(snap_good), 2);
        check("t3a_first_exp", 32'(snap_first_exp), 2);
        check("t3a_first_got", 32'(snap_first_got), 9);
        cyc(1'b0, 0, 1'b0);
        cyc(1'b1, 20, 1'b0);
        check("t3_err_pulse", 32'(err_pulse), 1);
        check("t3_locked_20", 32'(locked), 1);
        cyc(1'b1, 21, 1'b0);
        check("t3_err_pulse_low", 32'(err_pulse), 0);
        check("t3_locked_21", 32'(locked), 1);
        cyc(1'b0, 0, 1'b1);
        check("t3_err", 32'(snap_err), 1);
        check("t3_good", 32'(snap_good), 1);
        check("t3_first_exp", 32'(snap_first_exp), 12);
        check("t3_first_got", 32'(snap_first_got), 20);
        cyc(1'b0, 0, 1'b0);

        // 4: three mismatches lose lock, 0,1,2 regain it
        cyc(1'b1, 500, 1'b0);
        check("t4_locked_m1", 32'(locked), 1);
        cyc(1'b1, 700, 1'b0);
        check("t4_locked_m2", 32'(locked), 1);
        cyc(1'b1, 900, 1'b0);
        check("t4_locked_m3", 32'(locked), 0);
        check("t4_err_pulse_m3", 32'(err_pulse), 1);
        cyc(1'b1, 0, 1'b0);
        check("t4_search_no_pulse", 32'(err_pulse), 0);
        cyc(1'b1, 1, 1'b0);
        check("t4_relock_s1", 32'(locked), 0);
        cyc(1'b1, 2, 1'b0);
        check("t4_relock_s2", 32'(locked), 1);
        cyc(1'b0, 0, 1'b1);
        check("t4_err", 32'(snap_err), 3);
        check("t4_good", 32'(snap_good), 0);
        check("t4_wrap", 32'(snap_wrap), 0);
        check("t4_first_exp", 32'(snap_first_exp), 22);
        check("t4_first_got", 32'(snap_first_got), 500);
        cyc(1'b0, 0, 1'b0);

        // 5: request rises with a matching sample, held for 5 cycles
        cyc(1'b1, 3, 1'b0);
        acks = 0;
        cyc(1'b1, 4, 1'b1);
        acks += int'(snap_ack);
        check("t5_good", 32'(snap_good), 2);
        for (int i = 0; i < 4; i++) begin
            cyc(1'b0, 0, 1'b1);
            acks += int'(snap_ack);
        end
        check("t5_ack_count", 32'(acks), 1);
        cyc(1'b0, 0, 1'b0);
        cyc(1'b0, 0, 1'b1);
        check("t5_live_cleared", 32'(snap_good), 0);
        cyc(1'b0, 0, 1'b0);

        // 6: saturation on the 4-bit instance, then reset mid-stream
        for (int i = 5; i < 25; i++) cyc(1'b1, i, 1'b0);
        cyc(1'b0, 0, 1'b1);
        check("t6_good", 32'(snap_good), 20);
        check("t6_sat_good", 32'(s_snap_good), 15);
        cyc(1'b0, 0, 1'b0);
        cyc(1'b1, 25, 1'b1);
        rst = 1'b1;
        cyc(1'b1, 26, 1'b1);
        check("t6_rst_locked", 32'(locked), 0);
        check("t6_rst_ack", 32'(snap_ack), 0);
        check("t6_rst_good", 32'(snap_good), 0);
        check("t6_rst_err", 32'(snap_err), 0);
        check("t6_rst_wrap", 32'(snap_wrap), 0);
        check("t6_rst_first_got", 32'(snap_first_got), 0);
        check("t6_rst_sat_good", 32'(s_snap_good), 0);
        rst = 1'b0;
        cyc(1'b1, 0, 1'b0);
        check("t6_post_ack", 32'(snap_ack), 0);
        check("t6_post_s0", 32'(locked), 0);
        cyc(1'b1, 1, 1'b0);
        cyc(1'b1, 2, 1'b0);
        check("t6_post_relock", 32'(locked), 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
